// File: rtl/corelet_seq.sv
// Corelet sequencer: per kernel position loads weights, streams activations and
// drains the OFIFO into psum memory, then folds partial sums through the SFPs.
module corelet_seq #(
   parameter int unsigned row      = 4,
   parameter int unsigned col      = 8,
   parameter int unsigned len_kij  = 9,
   parameter int unsigned len_nij  = 36,
   parameter int unsigned len_onij = 16,
   parameter int unsigned addr_bw  = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               l0_full,
   input  logic               l0_ready,
   input  logic               o_valid,
   output logic               busy,
   output logic               done,
   output logic               l0_wr,
   output logic               l0_rd,
   output logic [1:0]         inst,
   output logic               ofifo_rd,
   output logic               acc,
   output logic               xmem_cen,
   output logic [addr_bw-1:0] xmem_addr,
   output logic               pmem_cen,
   output logic               pmem_wen,
   output logic [addr_bw-1:0] pmem_addr,
   output logic [3:0]         kij
);

   function automatic int unsigned isqrt(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 1; i <= v; i++) begin
         if (i * i <= v) r = i;
      end
      return r;
   endfunction

   localparam int unsigned SO    = isqrt(len_onij);
   localparam int unsigned SN    = isqrt(len_nij);
   localparam int unsigned SK    = isqrt(len_kij);
   localparam int unsigned XBASE = len_kij * col;
   localparam int unsigned CW    = $clog2(len_nij + row + col + len_kij + 1);
   localparam int unsigned OW    = $clog2(len_onij + 1);

   localparam logic [CW-1:0] C_W  = CW'(col - 1);
   localparam logic [CW-1:0] C_FL = CW'(row + col - 1);
   localparam logic [CW-1:0] C_X  = CW'(len_nij - 1);
   localparam logic [CW-1:0] C_N  = CW'(len_nij);
   localparam logic [CW-1:0] C_K  = CW'(len_kij);
   localparam logic [OW-1:0] C_O  = OW'(len_onij - 1);
   localparam logic [3:0]    C_KJ = 4'(len_kij - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_W_WR, S_W_LD, S_W_FL, S_X_WR, S_X_EX, S_DRAIN, S_NEXT, S_ACC, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [OW-1:0]      oc_q, oc_d;
   logic [3:0]         kij_q, kij_d;
   logic               l0wr_q, l0wr_d;
   logic               pwr_q, pwr_d;
   logic [addr_bw-1:0] pwaddr_q, pwaddr_d;
   logic               acc_q, acc_d;
   logic               prd;
   logic [addr_bw-1:0] paddr_rd;
   logic [31:0]        k_w, o_w, acc_addr_w;

   always_comb begin
      k_w        = 32'(cnt_q);
      o_w        = 32'(oc_q);
      acc_addr_w = k_w * len_nij + (o_w / SO) * SN + (o_w % SO) + (k_w / SK) * SN + (k_w % SK);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      oc_d      = oc_q;
      kij_d     = kij_q;
      l0wr_d    = 1'b0;
      pwr_d     = 1'b0;
      pwaddr_d  = pwaddr_q;
      acc_d     = 1'b0;
      prd       = 1'b0;
      paddr_rd  = '0;
      busy      = 1'b1;
      done      = 1'b0;
      l0_rd     = 1'b0;
      inst      = 2'b00;
      ofifo_rd  = 1'b0;
      xmem_cen  = 1'b1;
      xmem_addr = '0;

      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = S_W_WR;
               cnt_d   = '0;
               oc_d    = '0;
               kij_d   = '0;
            end
         end
         S_W_WR: begin
            xmem_addr = addr_bw'(32'(kij_q) * col + 32'(cnt_q));
            if (!l0_full) begin
               xmem_cen = 1'b0;
               l0wr_d   = 1'b1;
               if (cnt_q == C_W) begin
                  cnt_d   = '0;
                  state_d = S_W_LD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_W_LD: begin
            inst = 2'b01;
            // the last write's L0 strobe lands here; never read in that cycle
            if (l0_ready && !l0wr_q) begin
               l0_rd = 1'b1;
               if (cnt_q == C_W) begin
                  cnt_d   = '0;
                  state_d = S_W_FL;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_W_FL: begin
            if (cnt_q == C_FL) begin
               cnt_d   = '0;
               state_d = S_X_WR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_X_WR: begin
            xmem_addr = addr_bw'(XBASE + 32'(cnt_q));
            if (!l0_full) begin
               xmem_cen = 1'b0;
               l0wr_d   = 1'b1;
               if (cnt_q == C_X) begin
                  cnt_d   = '0;
                  state_d = S_X_EX;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_X_EX: begin
            inst = 2'b10;
            if (l0_ready && !l0wr_q) begin
               l0_rd = 1'b1;
               if (cnt_q == C_X) begin
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (cnt_q != C_N && o_valid) begin
               ofifo_rd = 1'b1;
               pwr_d    = 1'b1;
               pwaddr_d = addr_bw'(32'(kij_q) * len_nij + 32'(cnt_q));
               cnt_d    = cnt_q + 1'b1;
            end
            if (cnt_q == C_N && pwr_q) begin
               cnt_d   = '0;
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            cnt_d = '0;
            oc_d  = '0;
            if (kij_q < C_KJ) begin
               kij_d   = kij_q + 1'b1;
               state_d = S_W_WR;
            end else begin
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            // slots 0..len_kij-1 issue reads; the last slot gives the final acc beat
            if (cnt_q < C_K) begin
               prd      = 1'b1;
               paddr_rd = addr_bw'(acc_addr_w);
               acc_d    = 1'b1;
               cnt_d    = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               if (oc_q == C_O) state_d = S_DONE;
               else             oc_d    = oc_q + 1'b1;
            end
         end
         S_DONE: begin
            busy    = 1'b0;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         oc_q     <= '0;
         kij_q    <= '0;
         l0wr_q   <= 1'b0;
         pwr_q    <= 1'b0;
         pwaddr_q <= '0;
         acc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         oc_q     <= oc_d;
         kij_q    <= kij_d;
         l0wr_q   <= l0wr_d;
         pwr_q    <= pwr_d;
         pwaddr_q <= pwaddr_d;
         acc_q    <= acc_d;
      end
   end

   assign l0_wr     = l0wr_q;
   assign acc       = acc_q;
   assign kij       = kij_q;
   assign pmem_cen  = ~(pwr_q | prd);
   assign pmem_wen  = ~pwr_q;
   assign pmem_addr = pwr_q ? pwaddr_q : paddr_rd;

endmodule

// File: tb/tb_corelet_seq.sv
// Scoreboard bench for corelet_seq: expected SRAM address streams are queued at
// start and consumed as the sequencer issues accesses.
module tb_corelet_seq;

   localparam int unsigned AW = 11;

   logic          clk = 1'b0;
   logic          reset, start, l0_full, l0_ready, o_valid;
   logic          busy, done, l0_wr, l0_rd, ofifo_rd, acc;
   logic          xmem_cen, pmem_cen, pmem_wen;
   logic [1:0]    inst;
   logic [AW-1:0] xmem_addr, pmem_addr;
   logic [3:0]    kij;

   corelet_seq #(.row(4), .col(8), .len_kij(9), .len_nij(36), .len_onij(16), .addr_bw(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .l0_full(l0_full), .l0_ready(l0_ready),
      .o_valid(o_valid), .busy(busy), .done(done), .l0_wr(l0_wr), .l0_rd(l0_rd),
      .inst(inst), .ofifo_rd(ofifo_rd), .acc(acc), .xmem_cen(xmem_cen),
      .xmem_addr(xmem_addr), .pmem_cen(pmem_cen), .pmem_wen(pmem_wen),
      .pmem_addr(pmem_addr), .kij(kij)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int unsigned xq[$], pq[$], pkq[$], aq[$];
   int          pending = 0;
   int          nwr, nld, nex, nofr, nacc_out, ndone, acc_run;
   logic        tog_mode = 1'b0;
   logic        tog = 1'b0;
   logic        prev_full = 1'b0;
   logic [AW-1:0] prev_addr = '0;

   task automatic check(input string tag, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic clear_sb();
      xq.delete(); pq.delete(); pkq.delete(); aq.delete();
      pending = 0; nwr = 0; nld = 0; nex = 0; nofr = 0; nacc_out = 0; ndone = 0; acc_run = 0;
   endtask

   task automatic push_run();
      for (int unsigned k = 0; k < 9; k++) begin
         for (int unsigned i = 0; i < 8; i++)  xq.push_back(k * 8 + i);
         for (int unsigned i = 0; i < 36; i++) xq.push_back(72 + i);
         for (int unsigned i = 0; i < 36; i++) begin
            pq.push_back(k * 36 + i);
            pkq.push_back(k);
         end
      end
      for (int unsigned o = 0; o < 16; o++)
         for (int unsigned k = 0; k < 9; k++)
            aq.push_back(k * 36 + (o / 4) * 6 + (o % 4) + (k / 3) * 6 + (k % 3));
   endtask

   task automatic do_start();
      clear_sb();
      push_run();
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      @(negedge clk);
      check("busy_after_start", busy, 1);
   endtask

   task automatic check_reset_state();
      check("rst_busy", busy, 0);      check("rst_done", done, 0);
      check("rst_l0_wr", l0_wr, 0);    check("rst_l0_rd", l0_rd, 0);
      check("rst_inst", inst, 0);      check("rst_ofifo_rd", ofifo_rd, 0);
      check("rst_acc", acc, 0);        check("rst_xmem_cen", xmem_cen, 1);
      check("rst_pmem_cen", pmem_cen, 1); check("rst_pmem_wen", pmem_wen, 1);
      check("rst_xmem_addr", xmem_addr, 0); check("rst_pmem_addr", pmem_addr, 0);
      check("rst_kij", kij, 0);
   endtask

   task automatic wait_done();
      int unsigned n = 0;
      while (!done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done, 1);
      check("done_busy_low", busy, 0);
   endtask

   task automatic end_checks();
      repeat (20) @(negedge clk);
      check("n_l0_wr", nwr, 396);
      check("n_wload_rd", nld, 72);
      check("n_exec_rd", nex, 324);
      check("n_ofifo_rd", nofr, 324);
      check("n_acc_outputs", nacc_out, 16);
      check("n_done", ndone, 1);
      check("xq_left", xq.size(), 0);
      check("pq_left", pq.size(), 0);
      check("aq_left", aq.size(), 0);
      check("idle_busy", busy, 0);
   endtask

   // o_valid models the OFIFO: vectors become available after execute reads
   initial begin
      o_valid = 1'b0;
      forever begin
         @(posedge clk); #2;
         tog     = ~tog;
         o_valid = (pending > 0) && (!tog_mode || tog);
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         if (l0_rd) check("rd_excl", l0_wr, 0);
         if (l0_rd) check("rd_inst_valid", (inst == 2'b01 || inst == 2'b10) ? 1 : 0, 1);
         if (inst != 2'b00) check("inst_not_11", inst, (inst == 2'b11) ? 0 : inst);
         if (ofifo_rd) check("ofifo_needs_valid", o_valid, 1);
         if (l0_full) check("stall_cen", xmem_cen, 1);
         if (prev_full) check("stall_l0wr", l0_wr, 0);
         if (l0_full && prev_full) check("stall_addr", xmem_addr, prev_addr);
         if (!xmem_cen) begin
            if (xq.size() == 0) check("xq_underflow", 1, 0);
            else check("xmem_addr", xmem_addr, xq.pop_front());
         end
         if (!pmem_cen && !pmem_wen) begin
            if (pq.size() == 0) check("pq_underflow", 1, 0);
            else begin
               check("pmem_waddr", pmem_addr, pq.pop_front());
               check("kij_at_write", kij, pkq.pop_front());
            end
         end
         if (!pmem_cen && pmem_wen) begin
            if (aq.size() == 0) check("aq_underflow", 1, 0);
            else check("pmem_raddr", pmem_addr, aq.pop_front());
         end
         if (acc) acc_run++;
         else if (acc_run > 0) begin
            check("acc_run_len", acc_run, 9);
            nacc_out++;
            acc_run = 0;
         end
         if (l0_wr) nwr++;
         if (l0_rd && inst == 2'b01) nld++;
         if (l0_rd && inst == 2'b10) begin
            nex++;
            pending++;
         end
         if (ofifo_rd) begin
            nofr++;
            if (pending > 0) pending--;
         end
         if (done) ndone++;
      end
      prev_full = l0_full;
      prev_addr = xmem_addr;
   end

   initial begin
      int unsigned n;
      reset = 1'b0; start = 1'b0; l0_full = 1'b0; l0_ready = 1'b1;
      clear_sb();
      #23;
      check_reset_state();
      @(negedge clk); reset = 1'b1;

      // Run A: no stalls, start pulse during ACC must be ignored
      do_start();
      n = 0;
      while (!acc && n < 5000) begin @(negedge clk); n++; end
      check("acc_reached", acc, 1);
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      @(negedge clk);
      check("busy_ignores_start", busy, 1);
      wait_done();
      end_checks();

      // Run B: L0 full stall in X_WR, toggling o_valid, async abort in X_EX
      tog_mode = 1'b1;
      do_start();
      n = 0;
      while (!(xmem_cen == 1'b0 && xmem_addr >= 72) && n < 5000) begin @(negedge clk); n++; end
      check("xwr_reached", (xmem_addr >= 72) ? 1 : 0, 1);
      @(posedge clk); #2 l0_full = 1'b1;
      repeat (5) @(posedge clk);
      #2 l0_full = 1'b0;
      n = 0;
      while (!(inst == 2'b10 && kij == 4'd1) && n < 5000) begin @(negedge clk); n++; end
      check("xex_kij1_reached", inst, 2);
      #3 reset = 1'b0;
      #1 check_reset_state();
      clear_sb();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_no_done", ndone, 0);

      // Run C: clean run after abort with toggling o_valid
      do_start();
      check("restart_kij", kij, 0);
      wait_done();
      end_checks();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/corelet_seq.md
Name: corelet_seq

Overview:
Sequencer for one corelet: L0 input FIFO, MAC array, OFIFO and the per-column SFP accumulators.
For each of the len_kij kernel positions it:
- writes weights into L0 and loads them into the array;
- streams activations through the array;
- drains the OFIFO into psum memory.
It then runs the accumulation pass that folds the len_kij partial sums per output through the SFPs. It sits between the top-level testbench/host and the corelet, and owns all corelet control strobes plus the activation/psum SRAM address and enable lines.

Parameters:
row, 4, array rows (L0 width in lanes)
col, 8, array columns (weight vectors per kij)
len_kij, 9, kernel positions per run
len_nij, 36, activation vectors per kij
len_onij, 16, output pixels accumulated in the ACC pass
addr_bw, 11, SRAM address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse, begin a run (sampled in IDLE only)
l0_full  in  1  L0 cannot accept a write
l0_ready  in  1  L0 holds data for all rows
o_valid  in  1  OFIFO has a complete output vector
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run
l0_wr  out  1  L0 write strobe
l0_rd  out  1  L0 read strobe
inst  out  2  array instruction; [0]=kernel load, [1]=execute
ofifo_rd  out  1  OFIFO pop strobe
acc  out  1  SFP accumulate enable
xmem_cen  out  1  activation/weight SRAM chip enable, active-low
xmem_addr  out  addr_bw  activation/weight SRAM address
pmem_cen  out  1  psum SRAM chip enable, active-low
pmem_wen  out  1  psum SRAM write enable, active-low
pmem_addr  out  addr_bw  psum SRAM address
kij  out  4  current kernel position index

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; counters=0; kij=0.
  - All strobes low; xmem_cen/pmem_cen/pmem_wen high; addresses 0.
  - Reset mid-run aborts immediately; no done pulse.
- States and transitions:
  - IDLE: start -> W_WR.
  - W_WR: col L0 writes.
  - W_LD: col L0 reads with inst=01.
  - W_FL: row+col idle cycles to flush the kernel through the array; inst=00.
  - X_WR: len_nij L0 writes.
  - X_EX: len_nij L0 reads with inst=10.
  - DRAIN: pop len_nij OFIFO vectors into pmem.
  - NEXT: kij<len_kij-1 -> kij+1, W_WR; else -> ACC.
  - ACC: len_onij × len_kij pmem reads with acc=1.
  - DONE: single cycle -> IDLE.
- Write-phase handshake (W_WR, X_WR):
  - l0_wr and xmem_cen=0 only when l0_full=0; the count advances only on such cycles.
  - xmem_addr increments per accepted write: weights at base kij*col, activations at base len_kij*col.
  - SRAM read latency is 1 cycle, so l0_wr is the xmem_cen strobe delayed by one cycle.
  - Stall on full: hold the address, no strobe.
- Read-phase handshake (W_LD, X_EX):
  - l0_rd=1 only when l0_ready=1; the count advances only on such cycles.
  - inst is held for the whole state, including stalled cycles.
- DRAIN:
  - ofifo_rd=1 when o_valid=1.
  - One cycle later: pmem_cen=0, pmem_wen=0, pmem_addr=kij*len_nij+count.
  - Exit after len_nij pops and the final write.
- ACC, per output o:
  - len_kij reads at pmem_addr=k*len_nij+map(o,k), acc=1 aligned with the returned data.
  - map(o,k)=(o/ (sqrt(len_onij)))*sqrt(len_nij)+(o mod sqrt(len_onij))+(k/ sqrt(len_kij))*sqrt(len_nij)+(k mod sqrt(len_kij)). The square roots are compile-time constants (4, 6, 3 at default).
  - Then one cycle with acc=0 to present the result.
- Exclusivity:
  - l0_wr and l0_rd are never both high.
  - ofifo_rd is never high unless o_valid.
  - inst=11 is never produced.
- done is high for exactly 1 cycle in DONE; busy falls in the same cycle.
- start while busy is ignored.
- All counters saturate at their terminal value and never wrap mid-state.

Test Plan:
- Reset, then start with no stalls (l0_full=0, l0_ready=1, o_valid follows the array) -> exactly 8 W_WR writes, 8 inst=01 reads, 36 writes, 36 inst=10 reads and 36 pmem writes per kij; kij counts 0..8; done pulses once.
- Hold l0_full=1 for 5 cycles during X_WR -> no l0_wr and xmem_addr frozen in those cycles; total accepted writes still 36.
- Toggle o_valid 1/0 during DRAIN -> ofifo_rd only in o_valid cycles; pmem_addr sequence contiguous kij*36+0..35 with no gaps.
- ACC pass at defaults -> for o=0, pmem_addr reads 0, 37, 74, 114, 151, 188, 228, 265, 302 (k*36+map); acc high 9 cycles, then low 1 cycle; 16 outputs in total.
- Assert reset=0 asynchronously mid X_EX -> all outputs reach reset values before the next clk edge; a later start runs cleanly from kij=0.
- start pulsed during ACC -> ignored; busy stays high; exactly one done.
